nexi_uart_rx: RTL and testbench

NEXI_UART_RX -- requirements
Module: nexi_uart_rx

---
 rtl/nexi_uart_pkg.sv | 15 +
 rtl/nexi_uart_sync.sv | 23 ++
 rtl/nexi_uart_rx.sv | 184 ++++++++++++++++++
 tb/tb_nexi_uart_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/nexi_uart_pkg.sv
// Shared UART definitions: one-hot FSM state encoding and default framing constants.
package nexi_uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT = 16;
  localparam int unsigned UART_DATA_BITS    = 8;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } uart_state_t;

endpackage

// File: rtl/nexi_uart_sync.sv
// Two-flop synchronizer for a single asynchronous input; reset value is parameterised.
module nexi_uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nexi_uart_rx.sv
// UART receiver: mid-bit sampling, one-deep output register with sticky error flags.
// Optional parity stage enabled by defining NEXI_UART_RX_PARITY_EN.
module nexi_uart_rx
  import nexi_uart_pkg::*;
#(
`ifdef NEXI_UART_RX_PARITY_EN
  parameter bit          PARITY_ODD   = 1'b0,
`endif
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 err_clr,
`ifdef NEXI_UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  uart_state_t          state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [BW-1:0]        bits, bits_nxt;
  logic [DATA_BITS-1:0] sh;
  logic                 rx_s, tick, shift_en, stop_smp, byte_done, armed;
`ifdef NEXI_UART_RX_PARITY_EN
  logic                 par_smp;
`endif

  nexi_uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_pin),
    .q     (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      bits  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      bits  <= bits_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bits_nxt  = bits;
    shift_en  = 1'b0;
    stop_smp  = 1'b0;
`ifdef NEXI_UART_RX_PARITY_EN
    par_smp   = 1'b0;
`endif
    tick      = (cnt == '0);
    unique case (state)
      ST_IDLE: begin
        if (!rx_s && armed) begin
          state_nxt = ST_START;
          cnt_nxt   = HALF;
        end
      end
      ST_START: begin
        if (!tick) begin
          cnt_nxt = cnt - 1'b1;
        end else if (!rx_s) begin
          state_nxt = ST_DATA;
          cnt_nxt   = FULL;
          bits_nxt  = '0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!tick) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          shift_en = 1'b1;
          cnt_nxt  = FULL;
          if (bits == BW'(DATA_BITS - 1)) begin
            bits_nxt = '0;
`ifdef NEXI_UART_RX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end else begin
            bits_nxt = bits + 1'b1;
          end
        end
      end
      ST_PARITY: begin
`ifdef NEXI_UART_RX_PARITY_EN
        if (!tick) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          par_smp   = 1'b1;
          cnt_nxt   = FULL;
          state_nxt = ST_STOP;
        end
`else
        state_nxt = ST_IDLE;
`endif
      end
      ST_STOP: begin
        if (!tick) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          stop_smp  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // armed drops on a low stop bit so a stuck-low line cannot retrigger START
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh         <= '0;
      byte_done  <= 1'b0;
      armed      <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (shift_en)
        sh <= {rx_s, sh[DATA_BITS-1:1]};
      byte_done <= stop_smp;

      if (stop_smp && !rx_s)
        armed <= 1'b0;
      else if (state == ST_IDLE && rx_s)
        armed <= 1'b1;

      if (byte_done) begin
        data       <= sh;
        data_valid <= 1'b1;
      end else if (data_ack) begin
        data_valid <= 1'b0;
      end

      if (stop_smp && !rx_s)
        frame_err <= 1'b1;
      else if (err_clr)
        frame_err <= 1'b0;

      if (byte_done && data_valid && !data_ack)
        overrun <= 1'b1;
      else if (err_clr)
        overrun <= 1'b0;
    end
  end

`ifdef NEXI_UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      parity_err <= 1'b0;
    else if (par_smp && (rx_s != ((^sh) ^ PARITY_ODD)))
      parity_err <= 1'b1;
    else if (err_clr)
      parity_err <= 1'b0;
  end
`endif

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_nexi_uart_rx.sv
// Scoreboard bench for nexi_uart_rx: expected bytes queued at frame start, popped on data_valid rise.
module tb_nexi_uart_rx;

  localparam int unsigned CPB = 16;
`ifdef NEXI_UART_RX_PARITY_EN
  localparam int unsigned LAT = 156 + CPB;
`else
  localparam int unsigned LAT = 156;
`endif

  typedef struct {
    logic [7:0]  b;
    int unsigned c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_pin = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ack = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       err_clr = 1'b0;
  logic       busy;
`ifdef NEXI_UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  logic        prev_valid = 1'b0;
  exp_t        sb_q[$];

  nexi_uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_pin     (rx_pin),
    .data       (data),
    .data_valid (data_valid),
    .data_ack   (data_ack),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr),
`ifdef NEXI_UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && data_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("data", {24'd0, data}, {24'd0, e.b});
        check("latency", cyc - e.c, LAT);
      end
    end
    prev_valid <= data_valid;
  end

  task automatic send(input logic [7:0] b, input logic stop_bit, input logic par_bit, input bit push);
    @(negedge clk);
    rx_pin = 1'b0;
    if (push) sb_q.push_back('{b, cyc});
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef NEXI_UART_RX_PARITY_EN
    rx_pin = par_bit;
    repeat (CPB) @(negedge clk);
`else
    if (par_bit) rx_pin = 1'b1;
`endif
    rx_pin = stop_bit;
    repeat (CPB) @(negedge clk);
    rx_pin = 1'b1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(negedge clk);
    check("drain", sb_q.size(), 0);
    idle(4);
  endtask

  task automatic ack();
    @(negedge clk);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    check("valid_after_ack", {31'd0, data_valid}, 32'd0);
  endtask

  task automatic clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    idle(4);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_flags", {30'd0, frame_err, overrun}, 32'd0);
    rst_n = 1'b1;
    idle(10);

    // single frame
    send(8'h33, 1'b1, 1'b0, 1'b1);
    drain();
    check("t1_frame_err", {31'd0, frame_err}, 32'd0);
    check("t1_overrun", {31'd0, overrun}, 32'd0);
    ack();

    // back-to-back without ack -> overrun
    send(8'hCC, 1'b1, 1'b0, 1'b1);
    send(8'h11, 1'b1, 1'b1, 1'b0);
    idle(4);
    check("t2_data", {24'd0, data}, 32'h11);
    check("t2_valid", {31'd0, data_valid}, 32'd1);
    check("t2_overrun", {31'd0, overrun}, 32'd1);
    idle(20);
    check("t2_overrun_sticky", {31'd0, overrun}, 32'd1);
    ack();
    clr();
    check("t2_overrun_clr", {31'd0, overrun}, 32'd0);

    // stop bit low -> frame error, then clean recovery
    send(8'hA5, 1'b0, 1'b0, 1'b1);
    drain();
    check("t3_frame_err", {31'd0, frame_err}, 32'd1);
    idle(20);
    ack();
    send(8'h5A, 1'b1, 1'b0, 1'b1);
    drain();
    check("t3_frame_err_sticky", {31'd0, frame_err}, 32'd1);
    ack();
    clr();
    check("t3_frame_err_clr", {31'd0, frame_err}, 32'd0);

    // short glitch rejected
    @(negedge clk);
    rx_pin = 1'b0;
    idle(5);
    rx_pin = 1'b1;
    idle(40);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_valid", {31'd0, data_valid}, 32'd0);
    check("t4_flags", {30'd0, frame_err, overrun}, 32'd0);
    send(8'h01, 1'b1, 1'b1, 1'b1);
    drain();
    ack();

    // reset mid-DATA of 0xFF
    @(negedge clk);
    rx_pin = 1'b0;
    idle(CPB);
    rx_pin = 1'b1;
    idle(3 * CPB);
    rst_n = 1'b0;
    idle(3);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_data", {24'd0, data}, 32'd0);
    rst_n = 1'b1;
    idle(CPB * 8);
    check("t5_no_valid", {31'd0, data_valid}, 32'd0);
    send(8'h42, 1'b1, 1'b0, 1'b1);
    drain();
    check("t5_flags", {30'd0, frame_err, overrun}, 32'd0);
    ack();

`ifdef NEXI_UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0, 1'b1);
    drain();
    check("t6_parity_bad", {31'd0, parity_err}, 32'd1);
    ack();
    clr();
    check("t6_parity_clr", {31'd0, parity_err}, 32'd0);
    send(8'h07, 1'b1, 1'b1, 1'b1);
    drain();
    check("t6_parity_good", {31'd0, parity_err}, 32'd0);
    ack();
`endif

    idle(10);
    check("final_queue", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
